// File: rtl/candy_sram_wbuf.sv
// Posted-write buffer: queues writeback stores in a small FIFO and drains them to the SRAM port.
// Define CANDY_WBUF_FWD_EN to build the read-side forwarding comparators.
module candy_sram_wbuf #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              sram_req,
    input  logic              sram_gnt,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              empty,
    output logic              ovf,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StReq, StStrobe, StRecover} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  head_q, tail_q;
    logic [PTR_W:0]    count_q, count_d;
    logic [ADDR_W-1:0] sram_addr_q;
    logic [DATA_W-1:0] sram_wdata_q;
    logic              ovf_q;
    logic              full, push, pop;

    // DEPTH is a power of two, so the count MSB is set only when count == DEPTH.
    assign full     = count_q[PTR_W];
    assign push     = wr_valid && !full;
    assign pop      = (state_q == StStrobe);
    assign wr_ready = !full;
    assign empty    = (count_q == '0) && (state_q == StIdle);
    assign ovf      = ovf_q;

    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        sram_req = 1'b0;
        sram_we  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) state_d = StReq;
            end
            StReq: begin
                sram_req = 1'b1;
                if (sram_gnt) state_d = StStrobe;
            end
            StStrobe: begin
                sram_we = 1'b1;
                state_d = StRecover;
            end
            StRecover: begin
                state_d = (count_q != '0) ? StReq : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (push) tail_q <= tail_q + PTR_W'(1);
            if (pop) head_q <= head_q + PTR_W'(1);
            if (wr_valid && full) ovf_q <= 1'b1;
            if (state_q == StReq && sram_gnt) begin
                sram_addr_q  <= addr_mem[head_q];
                sram_wdata_q <= data_mem[head_q];
            end
        end
    end

    // Storage needs no reset: occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail_q] <= wr_addr;
            data_mem[tail_q] <= wr_data;
        end
    end

`ifdef CANDY_WBUF_FWD_EN
    // Walk oldest to newest so the newest matching entry overwrites earlier hits.
    always_comb begin
        logic [PTR_W-1:0] idx;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = head_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if (((PTR_W + 1)'(i) < count_q) && (addr_mem[idx] == rd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_mem[idx];
            end
        end
    end
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^rd_addr;
    assign fwd_hit        = 1'b0;
    assign fwd_data       = '0;
`endif

endmodule

// File: tb/tb_candy_sram_wbuf.sv
// Scoreboard bench for candy_sram_wbuf: directed writes queue expected SRAM strobes,
// a negedge monitor pops and compares each strobe as it appears.
module tb_candy_sram_wbuf;

`ifdef CANDY_WBUF_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        wr_valid;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        sram_req;
    logic        sram_gnt;
    logic        sram_we;
    logic [15:0] sram_addr;
    logic [31:0] sram_wdata;
    logic        empty;
    logic        ovf;
    logic [15:0] rd_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;

    candy_sram_wbuf #(
        .DATA_W(32),
        .ADDR_W(16),
        .DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .sram_req  (sram_req),
        .sram_gnt  (sram_gnt),
        .sram_we   (sram_we),
        .sram_addr (sram_addr),
        .sram_wdata(sram_wdata),
        .empty     (empty),
        .ovf       (ovf),
        .rd_addr   (rd_addr),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data)
    );

    // at: absolute strobe cycle (-1 = free); gap: cycles since previous strobe (0 = free)
    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
        int          at;
        int          gap;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   last_we = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty(input int limit, input string name);
        int n;
        n = 0;
        while (!empty && n < limit) begin
            tick();
            n++;
        end
        check(name, empty, 1);
    endtask

    task automatic write_q(input logic [15:0] a, input logic [31:0] d, input int at, input int gap);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        sb.push_back('{a, d, at, gap});
        tick();
        wr_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && sram_we) begin
            check("req_we_exclusive", sram_req, 0);
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_strobe: got addr %0h data %0h expected no strobe (cycle %0d)",
                         sram_addr, sram_wdata, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("strobe_addr", sram_addr, mon_e.addr);
                check("strobe_data", sram_wdata, mon_e.data);
                if (mon_e.at >= 0) check("strobe_cycle", cyc, mon_e.at);
                if (mon_e.gap > 0) check("strobe_gap", cyc - last_we, mon_e.gap);
            end
            last_we = cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        sram_gnt = 1'b0;
        rd_addr  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_sram_req", sram_req, 0);
        check("rst_sram_we", sram_we, 0);
        check("rst_sram_addr", sram_addr, 0);
        check("rst_sram_wdata", sram_wdata, 0);
        check("rst_ovf", ovf, 0);
        check("rst_empty", empty, 1);
        check("rst_wr_ready", wr_ready, 1);
        check("rst_fwd_hit", fwd_hit, 0);
        check("rst_fwd_data", fwd_data, 0);
        rst = 1'b0;
        tick();

        // Single write, grant tied high: strobe three cycles after the write is presented.
        sram_gnt = 1'b1;
        write_q(16'h0010, 32'hDEAD_BEEF, cyc + 3, 0);
        check("empty_after_accept", empty, 0);
        wait_empty(20, "empty_after_single");
        check("single_addr_held", sram_addr, 16'h0010);

        // Overfill with grant low, then hold grant low for 10 cycles.
        sram_gnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1;
            wr_addr  = 16'h0100 + 16'(4 * i);
            wr_data  = 32'hA000_0000 + 32'(i);
            check("fill_wr_ready", wr_ready, (i < 4) ? 1 : 0);
            if (i == 4) check("ovf_before_drop", ovf, 0);
            if (i < 4) sb.push_back('{wr_addr, wr_data, -1, (i == 0) ? 0 : 3});
            tick();
        end
        wr_valid = 1'b0;
        check("ovf_after_drop", ovf, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_req", sram_req, 1);
            check("stall_no_we", sram_we, 0);
        end
        sram_gnt = 1'b1;
        tick();
        check("we_after_grant", sram_we, 1);
        wait_empty(40, "empty_after_burst");
        check("ovf_sticky", ovf, 1);

        // Forwarding: newest of two same-address entries wins.
        sram_gnt = 1'b0;
        write_q(16'h0020, 32'h1, -1, 0);
        write_q(16'h0020, 32'h2, -1, 3);
        rd_addr = 16'h0020;
        #1;
        check("fwd_hit_match", fwd_hit, FWD);
        check("fwd_data_newest", fwd_data, FWD ? 32'h2 : 32'h0);
        rd_addr = 16'h0024;
        #1;
        check("fwd_hit_miss", fwd_hit, 0);
        check("fwd_data_miss", fwd_data, 0);
        rd_addr  = 16'h0020;
        sram_gnt = 1'b1;
        wait_empty(20, "empty_after_fwd");
        check("fwd_hit_drained", fwd_hit, 0);
        rd_addr = '0;

        // Push during STROBE with count = DEPTH-1: count stays, order preserved.
        sram_gnt = 1'b0;
        write_q(16'h0200, 32'hB0, -1, 0);
        write_q(16'h0204, 32'hB1, -1, 0);
        write_q(16'h0208, 32'hB2, -1, 3);
        tick();
        sram_gnt = 1'b1;
        tick();
        check("strobe_state", sram_we, 1);
        sram_gnt = 1'b0;
        check("strobe_wr_ready", wr_ready, 1);
        write_q(16'h020C, 32'hB3, -1, 3);
        check("count_unchanged_ready", wr_ready, 1);
        check("recover_no_we", sram_we, 0);
        repeat (3) tick();
        check("recover_to_req", sram_req, 1);
        sram_gnt = 1'b1;
        wait_empty(40, "empty_after_wrap");

        // Reset during STROBE: strobe drops at once, queued entries discarded.
        sram_gnt = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = 16'h0300;
        wr_data  = 32'hC0;
        tick();
        wr_addr  = 16'h0304;
        wr_data  = 32'hC1;
        tick();
        wr_valid = 1'b0;
        tick();
        sram_gnt = 1'b1;
        tick();
        check("pre_rst_strobe", sram_we, 1);
        rst = 1'b1;
        #1;
        check("rst_we_async", sram_we, 0);
        check("rst_mid_empty", empty, 1);
        check("rst_mid_ovf", ovf, 0);
        check("rst_mid_wr_ready", wr_ready, 1);
        tick();
        rst = 1'b0;
        repeat (12) tick();
        check("post_rst_empty", empty, 1);
        check("post_rst_no_req", sram_req, 0);

        check("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
